// File: rtl/led_panel_rx.sv
// Receive side of the HUB-style LED panel interface: resamples the panel lines,
// deserializes one row per latch, tracks the row address and flags protocol errors.
module led_panel_rx #(
   parameter int COLS = 32,
   parameter int ROWS = 8,
   parameter int CW   = $clog2(COLS + 1),
   localparam int RW  = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            red_in,
   input  logic            green_in,
   input  logic            blue_in,
   input  logic            sclk_in,
   input  logic            latch_in,
   input  logic            blank_in,
   input  logic            aclk_in,
   input  logic            arst_in,
   input  logic            clear_err,
   output logic [COLS-1:0] red_row,
   output logic [COLS-1:0] green_row,
   output logic [COLS-1:0] blue_row,
   output logic [RW-1:0]   row_out,
   output logic            row_valid,
   output logic            lit_out,
   output logic            err_count,
   output logic            err_tear
);

   localparam int R_B  = 0;
   localparam int G_B  = 1;
   localparam int B_B  = 2;
   localparam int SC_B = 3;
   localparam int LA_B = 4;
   localparam int BL_B = 5;
   localparam int AC_B = 6;
   localparam int AR_B = 7;

   localparam logic [CW-1:0] COLS_C = CW'(COLS);
   localparam logic [CW-1:0] SAT_C  = CW'(COLS + 1);

   logic [7:0]      s1_q, s2_q, rise;
   logic [COLS-1:0] red_sh_q, green_sh_q, blue_sh_q;
   logic [COLS-1:0] red_sh_d, green_sh_d, blue_sh_d;
   logic [COLS-1:0] red_row_q, green_row_q, blue_row_q;
   logic [COLS-1:0] red_row_d, green_row_d, blue_row_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_shift;
   logic [RW-1:0]   row_q, row_d, row_out_q, row_out_d;
   logic            valid_q, lit_q, err_count_q, err_tear_q;
   logic            err_count_d, err_tear_d;

   always_comb begin
      rise        = s1_q & ~s2_q;
      red_sh_d    = red_sh_q;
      green_sh_d  = green_sh_q;
      blue_sh_d   = blue_sh_q;
      cnt_shift   = cnt_q;
      if (rise[SC_B]) begin
         red_sh_d   = {red_sh_q[COLS-2:0],   s1_q[R_B]};
         green_sh_d = {green_sh_q[COLS-2:0], s1_q[G_B]};
         blue_sh_d  = {blue_sh_q[COLS-2:0],  s1_q[B_B]};
         if (cnt_q != SAT_C) cnt_shift = cnt_q + CW'(1);
      end

      // A latch coinciding with a shift sees the post-shift register and count.
      red_row_d   = red_row_q;
      green_row_d = green_row_q;
      blue_row_d  = blue_row_q;
      row_out_d   = row_out_q;
      cnt_d       = cnt_shift;
      err_count_d = err_count_q & ~clear_err;
      err_tear_d  = err_tear_q & ~clear_err;
      if (rise[LA_B]) begin
         red_row_d   = red_sh_d;
         green_row_d = green_sh_d;
         blue_row_d  = blue_sh_d;
         row_out_d   = row_q;
         cnt_d       = '0;
         if (cnt_shift != COLS_C) err_count_d = 1'b1;
         if (!s1_q[BL_B])         err_tear_d  = 1'b1;
      end

      row_d = row_q;
      if (s1_q[AR_B])      row_d = '0;
      else if (rise[AC_B]) row_d = row_q + RW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         red_sh_q    <= '0;
         green_sh_q  <= '0;
         blue_sh_q   <= '0;
         red_row_q   <= '0;
         green_row_q <= '0;
         blue_row_q  <= '0;
         cnt_q       <= '0;
         row_q       <= '0;
         row_out_q   <= '0;
         valid_q     <= 1'b0;
         lit_q       <= 1'b0;
         err_count_q <= 1'b0;
         err_tear_q  <= 1'b0;
      end else begin
         s1_q        <= {arst_in, aclk_in, blank_in, latch_in, sclk_in, blue_in, green_in, red_in};
         s2_q        <= s1_q;
         red_sh_q    <= red_sh_d;
         green_sh_q  <= green_sh_d;
         blue_sh_q   <= blue_sh_d;
         red_row_q   <= red_row_d;
         green_row_q <= green_row_d;
         blue_row_q  <= blue_row_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         row_out_q   <= row_out_d;
         valid_q     <= rise[LA_B];
         lit_q       <= ~s1_q[BL_B];
         err_count_q <= err_count_d;
         err_tear_q  <= err_tear_d;
      end
   end

   assign red_row   = red_row_q;
   assign green_row = green_row_q;
   assign blue_row  = blue_row_q;
   assign row_out   = row_out_q;
   assign row_valid = valid_q;
   assign lit_out   = lit_q;
   assign err_count = err_count_q;
   assign err_tear  = err_tear_q;

endmodule

// File: doc/led_panel_rx.md
# led_panel_rx

Receiver-side model of the HUB-style LED panel interface emitted by the panel driver (serial red/green/blue, sclk, latch, blank, aclk, arst). It samples those lines in the system clock domain and deserializes one row of COLS pixels per latch. It tracks the row address through aclk/arst and flags protocol violations. It sits on the receive end of the driver's pins: in the bench as a scoreboard front end, and on-chip as a loopback checker.

## Interface
Parameters:
- COLS, 32, pixels shifted per row; ≥2
- ROWS, 8, rows per frame; power of two, 2..8; RW = $clog2(ROWS)
- CW, $clog2(COLS+1), width of the shift counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- red_in / green_in / blue_in  in  1 each  serial pixel data
- sclk_in  in  1  shift clock; data sampled on its rising edge
- latch_in  in  1  transfer shift register to row outputs on its rising edge
- blank_in  in  1  high = display off
- aclk_in  in  1  row address advance on its rising edge
- arst_in  in  1  row address reset, level-sensitive, high active
- clear_err  in  1  synchronous clear of sticky error flags
- red_row / green_row / blue_row  out  COLS each  latched row pixels
- row_out  out  RW  row index associated with the latched row
- row_valid  out  1  one-cycle pulse when a row is latched
- lit_out  out  1  registered ~blank
- err_count  out  1  sticky: latch with shift count ≠ COLS
- err_tear  out  1  sticky: latch while blank low

## Operation
- Input stage: all eight panel inputs are registered into s1 every cycle, and s1 is copied into s2. Rising edge of X = X_s1 & ~X_s2.
- Shift: on sclk edge, each colour register does {reg[COLS-2:0], X_s1}. After COLS shifts, the first bit is at index COLS-1 and the last at index 0. The shift counter increments, saturating at COLS+1.
- Latch: on latch edge:
  - copy the three shift registers to the *_row outputs;
  - row_out ← current row counter;
  - pulse row_valid;
  - set err_count if count ≠ COLS;
  - set err_tear if blank_s1 = 0;
  - clear the counter to 0.
  - Shift registers are not cleared.
- Row counter (RW bits):
  - arst_s1 high forces it to 0 and overrides aclk;
  - otherwise an aclk edge increments it, wrapping ROWS-1 → 0.
- lit_out ← ~blank_s1 each cycle.
- Errors: once set, a flag holds until clear_err. If clear_err and a new violation occur in the same cycle, the flag ends up set.
- Simultaneous sclk and latch edges: the shift applies first; the latched row and the count check include that bit (count+1).
- Simultaneous aclk and latch edges: row_out takes the pre-increment value.
- Reset (async assert, any time): all registers 0. Every output is 0, including lit_out, row_valid and both errors. An in-progress row is discarded. s1/s2 = 0, so an input already high at deassertion produces an edge one cycle later.

## Timing
- An input change before clk edge n is in s1 at n and detected as an edge in the cycle after n. The resulting register updates (shift, row outputs, row_valid, row counter, errors) land at edge n+1. Input-to-output latency is 2 clocks.
- lit_out lags blank_in by 2 clocks.
- sclk high and low phases must each be ≥1 clk period, and data must be stable in the same cycle sclk rises. Shorter pulses are not required to be captured.
- row_valid is high for exactly 1 cycle per latch edge. A latch held high produces no further pulses.
- No back-pressure: consumers must sample *_row/row_out on row_valid. Outputs hold until the next latch.

## Test plan
- Reset mid-row: shift 10 bits, assert reset_n=0 → all outputs 0 immediately. After release, a full 32-bit row with clean latch → row_valid, no errors.
- Nominal row, COLS=32: shift red pattern 0x80000001-first-bit-MSB, green 0xFFFF0000, blue 0x0F0F0F0F, blank high, latch → row_valid 2 clocks after latch rise. Rows match exactly, row_out=0, err_count=0, err_tear=0.
- Row walk: arst pulse, then 9 aclk pulses with a latch after each (ROWS=8) → row_out sequence 1..7,0,1. arst held high with aclk toggling → row_out stays 0.
- Count error: latch after 31 shifts → err_count=1, data latched anyway. Next row of 32 shifts → flag stays 1. clear_err → 0. Latch after 33 shifts → err_count=1.
- Tear error: latch with blank low → err_tear=1, lit_out=1. clear_err asserted in the same cycle as another tearing latch → err_tear remains 1.
- Simultaneous sclk and latch edges on the 32nd bit → count accepted (no err_count), bit 0 equals the last data bit. Simultaneous aclk and latch edges → row_out equals the old row.
